// File: rtl/seq_arb_pkg.sv
// rtl/seq_arb_pkg.sv - shared types and helpers for the 4-input weighted sequential arbiter
// Contents: NUM_REQS, req_vec_t, onehot_to_idx(), is_onehot().
package seq_arb_pkg;

    localparam int NUM_REQS = 4;

    typedef logic [NUM_REQS-1:0] req_vec_t;

    // Index of the set bit; only meaningful when the vector is one-hot.
    function automatic logic [1:0] onehot_to_idx(input req_vec_t v);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (v[i]) begin
                idx = idx | 2'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic is_onehot(input req_vec_t v);
        return (v != '0) && ((v & (v - req_vec_t'(1))) == '0);
    endfunction

endpackage

// File: rtl/seq_arb_req_fifo.sv
// rtl/seq_arb_req_fifo.sv - single-input synchronous message FIFO feeding one arbiter request
// Ports: clk, reset (async, active-high), push_val/push_rdy/push_data (enqueue handshake),
//        pop (dequeue strobe, only asserted when non-empty), head (oldest entry), empty, full.
module seq_arb_req_fifo #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_val,
    output logic              push_rdy,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              empty,
    output logic              full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              push;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    // Ready depends only on occupancy: a full FIFO is not ready even if it pops this cycle.
    assign push_rdy = !full;
    assign push     = push_val && push_rdy;
    assign head     = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/seq_arb_4in_req_queue.sv
// rtl/seq_arb_4in_req_queue.sv - request-queue front end for the 4-input weighted sequential arbiter
// Ports: clk, reset (async, active-high); in_val/in_rdy/in_msg per-input enqueue;
//        reqs/grants/preset arbiter interface; out_val/out_rdy/out_msg/out_src output slot;
//        err (sticky invalid-grant flag) only when SEQ_ARB_REQ_QUEUE_ERR_EN is defined.
module seq_arb_4in_req_queue
    import seq_arb_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQS-1:0]          in_val,
    output logic [NUM_REQS-1:0]          in_rdy,
    input  logic [NUM_REQS*DATA_W-1:0]   in_msg,
    output logic [NUM_REQS-1:0]          reqs,
    input  logic [NUM_REQS-1:0]          grants,
    output logic                         preset,
    output logic                         out_val,
    input  logic                         out_rdy,
    output logic [DATA_W-1:0]            out_msg,
    output logic [1:0]                   out_src
`ifdef SEQ_ARB_REQ_QUEUE_ERR_EN
    ,
    output logic                         err
`endif
);

    logic [DATA_W-1:0] heads [NUM_REQS];
    req_vec_t          empty;
    req_vec_t          full;
    req_vec_t          pop;
    logic              slot_free;
    logic              grant_ok;
    logic              grant_bad;
    logic [1:0]        grant_idx;

    for (genvar i = 0; i < NUM_REQS; i++) begin : g_fifo
        seq_arb_req_fifo #(
            .DEPTH  (DEPTH),
            .DATA_W (DATA_W)
        ) u_fifo (
            .clk       (clk),
            .reset     (reset),
            .push_val  (in_val[i]),
            .push_rdy  (in_rdy[i]),
            .push_data (in_msg[i*DATA_W +: DATA_W]),
            .pop       (pop[i]),
            .head      (heads[i]),
            .empty     (empty[i]),
            .full      (full[i])
        );
    end

    // The slot can take a new message if it is empty or being drained this cycle;
    // while stalled no requester is presented to the arbiter.
    assign slot_free = !out_val || out_rdy;
    assign reqs      = ~empty & {NUM_REQS{slot_free}};

    assign grant_ok  = is_onehot(grants) && ((grants & reqs) != '0);
    assign grant_bad = (grants != '0) && !grant_ok;
    assign grant_idx = onehot_to_idx(grants);
    assign pop       = grant_ok ? grants : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_val <= 1'b0;
            out_msg <= '0;
            out_src <= '0;
        end else if (grant_ok) begin
            out_val <= 1'b1;
            out_msg <= heads[grant_idx];
            out_src <= grant_idx;
        end else if (out_val && out_rdy) begin
            out_val <= 1'b0;
        end
    end

    // Pending requests with no grant means every requester with data is out of weight.
    // The !preset term keeps the reload cycle (grants still 0) from producing a second pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            preset <= 1'b0;
        end else begin
            preset <= (|reqs) && (grants == '0) && !preset;
        end
    end

`ifdef SEQ_ARB_REQ_QUEUE_ERR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err <= 1'b0;
        end else if (grant_bad) begin
            err <= 1'b1;
        end
    end
`else
    logic unused_ok;
    assign unused_ok = &{1'b0, grant_bad, full};
`endif

endmodule

// File: tb/tb_seq_arb_4in_req_queue.sv
// tb/tb_seq_arb_4in_req_queue.sv - self-checking bench for seq_arb_4in_req_queue
module tb_seq_arb_4in_req_queue;

    localparam int DEPTH = 2;
    localparam int DW    = 8;

    typedef struct packed {
        logic [1:0]    src;
        logic [DW-1:0] msg;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset;
    logic [3:0]      in_val;
    logic [3:0]      in_rdy;
    logic [4*DW-1:0] in_msg;
    logic [3:0]      reqs;
    logic [3:0]      grants;
    logic            preset;
    logic            out_val;
    logic            out_rdy;
    logic [DW-1:0]   out_msg;
    logic [1:0]      out_src;
`ifdef SEQ_ARB_REQ_QUEUE_ERR_EN
    logic            err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] mq [4][$];
    exp_t          sb [$];
    logic          exp_val;
    logic          exp_preset;
    logic          exp_err;
    logic          ld;
    exp_t          e;

    always #5 clk = ~clk;

    seq_arb_4in_req_queue #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
        .clk     (clk),
        .reset   (reset),
        .in_val  (in_val),
        .in_rdy  (in_rdy),
        .in_msg  (in_msg),
        .reqs    (reqs),
        .grants  (grants),
        .preset  (preset),
        .out_val (out_val),
        .out_rdy (out_rdy),
        .out_msg (out_msg),
        .out_src (out_src)
`ifdef SEQ_ARB_REQ_QUEUE_ERR_EN
        ,
        .err     (err)
`endif
    );

    task automatic model_clear();
        for (int i = 0; i < 4; i++) mq[i].delete();
        sb.delete();
        exp_val    = 1'b0;
        exp_preset = 1'b0;
        exp_err    = 1'b0;
    endtask

    // Drives one clock cycle from a negedge to the next and advances the reference model.
    task automatic step(input logic [3:0] vals, input logic [4*DW-1:0] msgs,
                        input logic [3:0] g, output logic loaded);
        logic [3:0] mreqs;
        logic [3:0] acc;
        logic       sf;
        logic       valid;
        int         gi;
        exp_t       x;
        sf = !exp_val || out_rdy;
        for (int i = 0; i < 4; i++) begin
            mreqs[i] = (mq[i].size() != 0) && sf;
            acc[i]   = vals[i] && (mq[i].size() < DEPTH);
        end
        in_val = vals;
        in_msg = msgs;
        grants = g;
        valid  = ($countones(g) == 1) && ((g & mreqs) != 4'b0000);
        loaded = valid;
        gi = 0;
        for (int i = 0; i < 4; i++) if (g[i]) gi = i;
        if (valid) begin
            x.src = gi[1:0];
            x.msg = mq[gi].pop_front();
            sb.push_back(x);
        end
        for (int i = 0; i < 4; i++) begin
            if (acc[i]) mq[i].push_back(msgs[i*DW +: DW]);
        end
        exp_preset = (|mreqs) && (g == 4'b0000) && !exp_preset;
        if (valid) exp_val = 1'b1;
        else if (exp_val && out_rdy) exp_val = 1'b0;
        if (g != 4'b0000 && !valid) exp_err = 1'b1;
        @(negedge clk);
        in_val = '0;
        grants = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_clear();
        #1;
        n_checks++; if (in_rdy !== 4'b1111) begin n_fail++; $display("FAIL reset_in_rdy: got %b want 1111", in_rdy); end
        n_checks++; if (reqs !== 4'b0000) begin n_fail++; $display("FAIL reset_reqs: got %b want 0000", reqs); end
        n_checks++; if (preset !== 1'b0) begin n_fail++; $display("FAIL reset_preset: got %b want 0", preset); end
        n_checks++; if (out_val !== 1'b0) begin n_fail++; $display("FAIL reset_out_val: got %b want 0", out_val); end
        n_checks++; if (out_msg !== 8'h00 || out_src !== 2'd0) begin n_fail++; $display("FAIL reset_out_data: got msg=%h src=%0d want 00/0", out_msg, out_src); end
`ifdef SEQ_ARB_REQ_QUEUE_ERR_EN
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
`endif
        @(negedge clk);
    endtask

    task automatic test_single();
        step(4'b0100, {8'h00, 8'hA5, 8'h00, 8'h00}, 4'b0000, ld);
        n_checks++; if (reqs !== 4'b0100) begin n_fail++; $display("FAIL single_reqs: got %b want 0100", reqs); end
        step(4'b0000, '0, 4'b0100, ld);
        n_checks++; if (!ld || sb.size() == 0) begin n_fail++; $display("FAIL single_load: got no expected load want one"); end
        else begin
            e = sb.pop_front();
            if (out_val !== 1'b1 || out_msg !== e.msg || out_src !== e.src) begin
                n_fail++; $display("FAIL single_out: got val=%b msg=%h src=%0d want val=1 msg=%h src=%0d", out_val, out_msg, out_src, e.msg, e.src);
            end
        end
        n_checks++; if (reqs !== 4'b0000) begin n_fail++; $display("FAIL single_reqs_after: got %b want 0000", reqs); end
        step(4'b0000, '0, 4'b0000, ld);
        n_checks++; if (out_val !== exp_val) begin n_fail++; $display("FAIL single_drain: got %b want %b", out_val, exp_val); end
    endtask

    task automatic test_fill();
        step(4'b0001, {24'h0, 8'h11}, 4'b0000, ld);
        n_checks++; if (in_rdy[0] !== 1'b1) begin n_fail++; $display("FAIL fill_rdy_one: got %b want 1", in_rdy[0]); end
        step(4'b0001, {24'h0, 8'h22}, 4'b0000, ld);
        n_checks++; if (in_rdy[0] !== 1'b0) begin n_fail++; $display("FAIL fill_rdy_full: got %b want 0", in_rdy[0]); end
        for (int k = 0; k < 2; k++) begin
            step(4'b0000, '0, 4'b0001, ld);
            n_checks++; if (!ld || sb.size() == 0) begin n_fail++; $display("FAIL fill_load%0d: got no expected load want one", k); end
            else begin
                e = sb.pop_front();
                if (out_val !== 1'b1 || out_msg !== e.msg || out_src !== e.src) begin
                    n_fail++; $display("FAIL fill_out%0d: got val=%b msg=%h src=%0d want val=1 msg=%h src=%0d", k, out_val, out_msg, out_src, e.msg, e.src);
                end
            end
            n_checks++; if (in_rdy[0] !== 1'b1) begin n_fail++; $display("FAIL fill_rdy_after%0d: got %b want 1", k, in_rdy[0]); end
        end
        step(4'b0000, '0, 4'b0000, ld);
    endtask

    task automatic test_stall();
        step(4'b1010, {8'h44, 8'h00, 8'h33, 8'h00}, 4'b0000, ld);
        step(4'b0000, '0, 4'b0010, ld);
        n_checks++; if (!ld || sb.size() == 0) begin n_fail++; $display("FAIL stall_first_load: got no expected load want one"); end
        else begin
            e = sb.pop_front();
            if (out_val !== 1'b1 || out_msg !== e.msg || out_src !== e.src) begin
                n_fail++; $display("FAIL stall_first_out: got val=%b msg=%h src=%0d want val=1 msg=%h src=%0d", out_val, out_msg, out_src, e.msg, e.src);
            end
        end
        out_rdy = 1'b0;
        #1;
        n_checks++; if (reqs !== 4'b0000) begin n_fail++; $display("FAIL stall_reqs: got %b want 0000", reqs); end
        step(4'b0000, '0, 4'b0000, ld);
        n_checks++; if (out_val !== 1'b1 || out_msg !== 8'h33) begin n_fail++; $display("FAIL stall_hold: got val=%b msg=%h want val=1 msg=33", out_val, out_msg); end
        out_rdy = 1'b1;
        step(4'b0000, '0, 4'b1000, ld);
        n_checks++; if (!ld || sb.size() == 0) begin n_fail++; $display("FAIL b2b_load: got no expected load want one"); end
        else begin
            e = sb.pop_front();
            if (out_val !== 1'b1 || out_msg !== e.msg || out_src !== e.src) begin
                n_fail++; $display("FAIL b2b_out: got val=%b msg=%h src=%0d want val=1 msg=%h src=%0d", out_val, out_msg, out_src, e.msg, e.src);
            end
        end
        step(4'b0000, '0, 4'b0000, ld);
    endtask

    task automatic test_preset();
        step(4'b0010, {8'h00, 8'h00, 8'h55, 8'h00}, 4'b0000, ld);
        n_checks++; if (preset !== 1'b0) begin n_fail++; $display("FAIL preset_idle: got %b want 0", preset); end
        step(4'b0000, '0, 4'b0000, ld);
        n_checks++; if (preset !== exp_preset || preset !== 1'b1) begin n_fail++; $display("FAIL preset_pulse: got %b want 1", preset); end
        step(4'b0000, '0, 4'b0000, ld);
        n_checks++; if (preset !== 1'b0) begin n_fail++; $display("FAIL preset_single: got %b want 0", preset); end
        step(4'b0000, '0, 4'b0010, ld);
        n_checks++; if (preset !== 1'b0) begin n_fail++; $display("FAIL preset_after_grant: got %b want 0", preset); end
        n_checks++; if (!ld || sb.size() == 0) begin n_fail++; $display("FAIL preset_load: got no expected load want one"); end
        else begin
            e = sb.pop_front();
            if (out_val !== 1'b1 || out_msg !== e.msg || out_src !== e.src) begin
                n_fail++; $display("FAIL preset_out: got val=%b msg=%h src=%0d want val=1 msg=%h src=%0d", out_val, out_msg, out_src, e.msg, e.src);
            end
        end
        step(4'b0000, '0, 4'b0000, ld);
    endtask

    task automatic test_invalid();
        step(4'b0011, {8'h00, 8'h00, 8'h77, 8'h66}, 4'b0000, ld);
        step(4'b0000, '0, 4'b0011, ld);
        n_checks++; if (out_val !== 1'b0 || ld) begin n_fail++; $display("FAIL invalid_multi: got out_val=%b want 0", out_val); end
`ifdef SEQ_ARB_REQ_QUEUE_ERR_EN
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL invalid_err_set: got %b want 1", err); end
`endif
        step(4'b0000, '0, 4'b1000, ld);
        n_checks++; if (out_val !== 1'b0 || ld) begin n_fail++; $display("FAIL invalid_empty: got out_val=%b want 0", out_val); end
        for (int k = 0; k < 2; k++) begin
            step(4'b0000, '0, 4'(1 << k), ld);
            n_checks++; if (!ld || sb.size() == 0) begin n_fail++; $display("FAIL invalid_follow_load%0d: got no expected load want one", k); end
            else begin
                e = sb.pop_front();
                if (out_val !== 1'b1 || out_msg !== e.msg || out_src !== e.src) begin
                    n_fail++; $display("FAIL invalid_follow%0d: got val=%b msg=%h src=%0d want val=1 msg=%h src=%0d", k, out_val, out_msg, out_src, e.msg, e.src);
                end
            end
        end
        step(4'b0000, '0, 4'b0000, ld);
`ifdef SEQ_ARB_REQ_QUEUE_ERR_EN
        n_checks++; if (err !== exp_err) begin n_fail++; $display("FAIL invalid_err_sticky: got %b want %b", err, exp_err); end
`endif
    endtask

    task automatic test_reset_mid();
        step(4'b0100, {8'h00, 8'h88, 8'h00, 8'h00}, 4'b0000, ld);
        step(4'b0000, '0, 4'b0100, ld);
        reset = 1'b1;
        #1;
        n_checks++; if (out_val !== 1'b0) begin n_fail++; $display("FAIL midreset_out_val: got %b want 0", out_val); end
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        step(4'b0001, {24'h0, 8'h99}, 4'b0000, ld);
        step(4'b0000, '0, 4'b0000, ld);
        n_checks++; if (preset !== 1'b1) begin n_fail++; $display("FAIL midreset_preset_pre: got %b want 1", preset); end
        reset = 1'b1;
        #1;
        n_checks++; if (preset !== 1'b0) begin n_fail++; $display("FAIL midreset_preset: got %b want 0", preset); end
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        #1;
        n_checks++; if (in_rdy !== 4'b1111 || reqs !== 4'b0000) begin n_fail++; $display("FAIL midreset_flush: got in_rdy=%b reqs=%b want 1111/0000", in_rdy, reqs); end
`ifdef SEQ_ARB_REQ_QUEUE_ERR_EN
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL midreset_err: got %b want 0", err); end
`endif
    endtask

    initial begin
        reset   = 1'b1;
        in_val  = '0;
        in_msg  = '0;
        grants  = '0;
        out_rdy = 1'b1;
        model_clear();
        @(negedge clk);
        test_reset();
        test_single();
        test_fill();
        test_stall();
        test_preset();
        test_invalid();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
